// File: rtl/lsu_mem_seq.sv
// Load/store sequencer between the MEM stage and a single-ported word-addressed
// data memory with a grant/rvalid handshake.
module lsu_mem_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched request: only the fields the later states still need
    logic       we_q;
    logic [2:0] op_q;
    logic [1:0] off_q;

    logic                  accept_c;
    logic                  err_c;
    logic                  we_d;
    logic                  capture_c;
    logic [3:0]            wstrb_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic [DATA_WIDTH-1:0] shifted_c;
    logic [DATA_WIDTH-1:0] load_c;

    assign accept_c = req_valid && req_ready;

    // Misalignment / illegal-op classification of the incoming request
    always_comb begin
        err_c = 1'b0;
        case (req_op)
            OP_B:    err_c = 1'b0;
            OP_BU:   err_c = req_we;
            OP_H:    err_c = req_addr[0];
            OP_HU:   err_c = req_we | req_addr[0];
            OP_W:    err_c = (req_addr[1:0] != 2'b00);
            default: err_c = 1'b1;
        endcase
    end

    // Store lane replication and byte strobes
    always_comb begin
        wdata_c = req_wdata;
        wstrb_c = 4'b1111;
        case (req_op[1:0])
            2'b00: begin
                wdata_c = {(DATA_WIDTH/BYTE_W){req_wdata[BYTE_W-1:0]}};
                wstrb_c = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                wdata_c = {(DATA_WIDTH/HALF_W){req_wdata[HALF_W-1:0]}};
                wstrb_c = 4'b0011 << req_addr[1:0];
            end
            default: begin
                wdata_c = req_wdata;
                wstrb_c = 4'b1111;
            end
        endcase
    end

    // Load alignment and extension from the latched op/offset
    always_comb begin
        shifted_c = mem_rdata >> {off_q, 3'b000};
        load_c    = shifted_c;
        case (op_q)
            OP_B:    load_c = {{(DATA_WIDTH-BYTE_W){shifted_c[BYTE_W-1]}}, shifted_c[BYTE_W-1:0]};
            OP_H:    load_c = {{(DATA_WIDTH-HALF_W){shifted_c[HALF_W-1]}}, shifted_c[HALF_W-1:0]};
            OP_BU:   load_c = {{(DATA_WIDTH-BYTE_W){1'b0}}, shifted_c[BYTE_W-1:0]};
            OP_HU:   load_c = {{(DATA_WIDTH-HALF_W){1'b0}}, shifted_c[HALF_W-1:0]};
            default: load_c = shifted_c;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        we_d      = accept_c ? req_we : we_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = err_c ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = RESP;
                    end else if (mem_rvalid) begin
                        state_d   = RESP;
                        capture_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d   = RESP;
                    capture_c = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            op_q       <= 3'b000;
            off_q      <= 2'b00;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= 4'b0000;
        end else begin
            state_q    <= state_d;
            req_ready  <= (state_d == IDLE);
            busy       <= (state_d != IDLE);
            mem_req    <= (state_d == REQ);
            mem_we     <= (state_d == REQ) && we_d;
            resp_valid <= (state_d == RESP);
            resp_err   <= accept_c && err_c;

            if (accept_c) begin
                we_q      <= req_we;
                op_q      <= req_op;
                off_q     <= req_addr[1:0];
                mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata <= wdata_c;
                mem_wstrb <= req_we ? wstrb_c : 4'b0000;
            end

            // Load data persists until the next load; stores and errors clear it
            if (capture_c) begin
                resp_rdata <= load_c;
            end else if ((state_d == RESP) && (state_q != RESP)) begin
                resp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_seq.sv
// Directed bench for lsu_mem_seq: each task drives one scenario cycle by cycle
// and compares outputs against hand-computed values.
module tb_lsu_mem_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int pass_cnt = 0;
    int total    = 0;
    int gnt_cnt  = 0;
    logic [31:0] last_gnt_addr = '0;
    logic        last_gnt_we   = 1'b0;

    lsu_mem_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted memory request
    always @(posedge clk) begin
        if (!rst && mem_req && mem_gnt) begin
            gnt_cnt++;
            last_gnt_addr = mem_addr;
            last_gnt_we   = mem_we;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({req_ready, busy, mem_req, mem_we, resp_valid, resp_err} !== 6'b100000)
            $display("FAIL reset_ctrl got %b exp 100000",
                     {req_ready, busy, mem_req, mem_we, resp_valid, resp_err});
        else pass_cnt++;
        total++;
        if (resp_rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", resp_rdata);
        else pass_cnt++;
        total++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0)
            $display("FAIL reset_mem got %h/%h/%b exp 0", mem_addr, mem_wdata, mem_wstrb);
        else pass_cnt++;
    endtask

    task automatic test_load_half(input logic [2:0] op, input logic [31:0] exp, input string nm);
        set_req(1'b0, op, 32'h0000_0102, 32'h0);
        tick();
        req_valid = 1'b0;
        total++;
        if ({mem_req, mem_we, mem_wstrb} !== 6'b100000 || mem_addr !== 32'h100)
            $display("FAIL %s_req got req=%b we=%b strb=%b addr=%h exp 1/0/0000/100",
                     nm, mem_req, mem_we, mem_wstrb, mem_addr);
        else pass_cnt++;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        total++;
        if ({mem_req, busy, resp_valid} !== 3'b010)
            $display("FAIL %s_wait got req/busy/rv=%b exp 010", nm, {mem_req, busy, resp_valid});
        else pass_cnt++;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8001_1234;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        total++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== exp)
            $display("FAIL %s_resp got v=%b e=%b d=%h exp 1/0/%h", nm, resp_valid, resp_err, resp_rdata, exp);
        else pass_cnt++;
        tick();
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== exp)
            $display("FAIL %s_hold got v=%b rdy=%b d=%h exp 0/1/%h", nm, resp_valid, req_ready, resp_rdata, exp);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        logic        wes   [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  ops   [3] = '{3'b010, 3'b001, 3'b011};
        logic [31:0] addrs [3] = '{32'h101, 32'h103, 32'h0};
        for (int i = 0; i < 3; i++) begin
            set_req(wes[i], ops[i], addrs[i], 32'hFFFF_FFFF);
            tick();
            req_valid = 1'b0;
            total++;
            if ({mem_req, resp_valid, resp_err} !== 3'b011 || resp_rdata !== 32'h0)
                $display("FAIL err%0d_resp got req/v/e=%b d=%h exp 011/0", i,
                         {mem_req, resp_valid, resp_err}, resp_rdata);
            else pass_cnt++;
            tick();
            total++;
            if ({mem_req, resp_valid, resp_err, req_ready} !== 4'b0001)
                $display("FAIL err%0d_after got req/v/e/rdy=%b exp 0001", i,
                         {mem_req, resp_valid, resp_err, req_ready});
            else pass_cnt++;
        end
    endtask

    task automatic test_store_byte();
        set_req(1'b1, 3'b000, 32'h203, 32'h0000_00AB);
        tick();
        req_valid = 1'b0;
        total++;
        if ({mem_req, mem_we, resp_valid} !== 3'b110 || mem_addr !== 32'h200 ||
            mem_wdata !== 32'hABAB_ABAB || mem_wstrb !== 4'b1000)
            $display("FAIL sb_req got req/we/v=%b addr=%h wd=%h strb=%b exp 110/200/ababab ab/1000",
                     {mem_req, mem_we, resp_valid}, mem_addr, mem_wdata, mem_wstrb);
        else pass_cnt++;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        total++;
        if ({resp_valid, resp_err, mem_req} !== 3'b100 || resp_rdata !== 32'h0)
            $display("FAIL sb_resp got v/e/req=%b d=%h exp 100/0", {resp_valid, resp_err, mem_req}, resp_rdata);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_stall_store();
        set_req(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({mem_req, busy, req_ready, mem_we, resp_valid} !== 5'b11010 || mem_addr !== 32'h40 ||
                mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'b1111)
                $display("FAIL sw_stall%0d got req/busy/rdy/we/v=%b addr=%h wd=%h strb=%b exp 11010/40/deadbeef/1111",
                         i, {mem_req, busy, req_ready, mem_we, resp_valid}, mem_addr, mem_wdata, mem_wstrb);
            else pass_cnt++;
            if (i == 3) mem_gnt = 1'b1;
            tick();
        end
        mem_gnt = 1'b0;
        total++;
        if ({resp_valid, mem_req, busy} !== 3'b101)
            $display("FAIL sw_resp got v/req/busy=%b exp 101", {resp_valid, mem_req, busy});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(1'b0, 3'b000, 32'h7, 32'h0);
        tick();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        tick();
        mem_gnt = 1'b0;
        total++;
        if ({mem_req, busy} !== 2'b01)
            $display("FAIL lb_wait got req/busy=%b exp 01", {mem_req, busy});
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({req_ready, busy, mem_req, resp_valid} !== 4'b1000 || resp_rdata !== 32'h0)
            $display("FAIL midrst got rdy/busy/req/v=%b d=%h exp 1000/0",
                     {req_ready, busy, mem_req, resp_valid}, resp_rdata);
        else pass_cnt++;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        total++;
        if ({resp_valid, busy, req_ready} !== 3'b001 || resp_rdata !== 32'h0)
            $display("FAIL stale_rvalid got v/busy/rdy=%b d=%h exp 001/0",
                     {resp_valid, busy, req_ready}, resp_rdata);
        else pass_cnt++;
        set_req(1'b0, 3'b100, 32'h7, 32'h0);
        tick();
        req_valid  = 1'b0;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h9A00_0000;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        total++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0000_009A)
            $display("FAIL lbu_resp got v=%b e=%b d=%h exp 1/0/0000009a", resp_valid, resp_err, resp_rdata);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        int base;
        base = gnt_cnt;
        set_req(1'b0, 3'b010, 32'h10, 32'h0);
        tick();
        set_req(1'b1, 3'b010, 32'h14, 32'h55AA_55AA);
        total++;
        if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h10)
            $display("FAIL b2b_lw_req got req/we=%b addr=%h exp 10/10", {mem_req, mem_we}, mem_addr);
        else pass_cnt++;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1122_3344;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        total++;
        if ({resp_valid, req_ready} !== 2'b10 || resp_rdata !== 32'h1122_3344 || gnt_cnt - base !== 1 ||
            last_gnt_addr !== 32'h10)
            $display("FAIL b2b_lw_resp got v/rdy=%b d=%h gnts=%0d gaddr=%h exp 10/11223344/1/10",
                     {resp_valid, req_ready}, resp_rdata, gnt_cnt - base, last_gnt_addr);
        else pass_cnt++;
        tick();
        total++;
        if ({req_ready, resp_valid, mem_req} !== 3'b100)
            $display("FAIL b2b_idle got rdy/v/req=%b exp 100", {req_ready, resp_valid, mem_req});
        else pass_cnt++;
        tick();
        req_valid = 1'b0;
        total++;
        if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h14 || mem_wdata !== 32'h55AA_55AA ||
            mem_wstrb !== 4'b1111)
            $display("FAIL b2b_sw_req got req/we=%b addr=%h wd=%h strb=%b exp 11/14/55aa55aa/1111",
                     {mem_req, mem_we}, mem_addr, mem_wdata, mem_wstrb);
        else pass_cnt++;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        total++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || gnt_cnt - base !== 2 ||
            last_gnt_addr !== 32'h14 || last_gnt_we !== 1'b1)
            $display("FAIL b2b_sw_resp got v=%b d=%h gnts=%0d gaddr=%h gwe=%b exp 1/0/2/14/1",
                     resp_valid, resp_rdata, gnt_cnt - base, last_gnt_addr, last_gnt_we);
        else pass_cnt++;
        tick();
        total++;
        if ({req_ready, busy, resp_valid, mem_req} !== 4'b1000)
            $display("FAIL b2b_end got rdy/busy/v/req=%b exp 1000", {req_ready, busy, resp_valid, mem_req});
        else pass_cnt++;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_op     = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        test_reset();
        test_load_half(3'b001, 32'hFFFF_8001, "lh");
        test_load_half(3'b101, 32'h0000_8001, "lhu");
        test_errors();
        test_store_byte();
        test_stall_store();
        test_reset_mid();
        test_back_to_back();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
